// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: reset sequencer and run supervisor for one or more CPU cores.
//   Takes the raw asynchronous reset and synchronises its release. It holds the
//   core resets for a stretch period, then releases them one channel at a time.
//   While the cores run, it counts cycles and watches core 0's PC. A PC that
//   stops changing means the core has halted. It also stops the run when the
//   cycle budget is used up.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   restart_i   synchronous pulse that re-runs the whole reset sequence
//   pc_i        PC of supervised core 0
//   rst_n_o     per-channel active-low core resets, bit k releases k-th
//   running_o   high while in RUN
//   done_o      sticky, run terminated (halt or timeout)
//   halted_o    sticky, PC-stall termination
//   timeout_o   sticky, cycle budget exhausted
//   cycle_cnt_o RUN cycles elapsed, frozen on termination
//   final_pc_o  pc_i captured in the terminating cycle
module cpu_run_ctrl #(
  parameter int XLEN         = 64,
  parameter int N_RST        = 2,
  parameter int RST_STRETCH  = 4,
  parameter int STAGGER      = 2,
  parameter int STALL_CYCLES = 8,
  parameter int MAX_CYCLES   = 120,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [N_RST-1:0] rst_n_o,
  output logic             running_o,
  output logic             done_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [XLEN-1:0]  final_pc_o
);

  // Number of cycles from RELEASE entry until the last channel is released.
  localparam int LAST_REL = (N_RST - 1) * STAGGER;
  localparam int REL_W    = $clog2(LAST_REL + 1) + 1;
  localparam int ST_W     = $clog2(RST_STRETCH) + 1;
  localparam int SC_W     = $clog2(STALL_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_ASSERT,
    S_RELEASE,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic [ST_W-1:0]   str_cnt;
  logic [REL_W-1:0]  rel_cnt;
  logic [SC_W-1:0]   stall_cnt;
  logic [XLEN-1:0]   last_pc;
  logic              pc_vld;
  logic [N_RST-1:0]  rst_n_q, rst_n_d;

  logic stall_eq, halt_hit, tmo_hit, str_done, rel_last;

  // last_pc is only meaningful after the first RUN cycle has loaded it.
  assign stall_eq = pc_vld && (pc_i == last_pc);
  // This compare brings stall_cnt to STALL_CYCLES-1, so this cycle terminates.
  assign halt_hit = stall_eq && (stall_cnt == SC_W'(STALL_CYCLES - 2));
  assign tmo_hit  = (cycle_cnt_o == CNT_W'(MAX_CYCLES - 1));
  // The stretch only starts counting once the synchroniser has released.
  assign str_done = sync_q[1] && (str_cnt == ST_W'(RST_STRETCH - 1));
  assign rel_last = ((int'(rel_cnt) + 1) == LAST_REL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      // With no stagger, every channel releases on the ASSERT exit edge.
      S_ASSERT:  if (str_done) state_d = (LAST_REL == 0) ? S_RUN : S_RELEASE;
      S_RELEASE: if (rel_last) state_d = S_RUN;
      S_RUN: begin
        if (halt_hit)     state_d = S_HALTED;
        else if (tmo_hit) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
    if (restart_i) state_d = S_ASSERT;
  end

  // Released bits are never cleared except by restart or reset.
  always_comb begin
    rst_n_d = rst_n_q;
    for (int k = 0; k < N_RST; k++) begin
      if (state_q == S_ASSERT && str_done && k * STAGGER == 0)
        rst_n_d[k] = 1'b1;
      if (state_q == S_RELEASE && (int'(rel_cnt) + 1) == k * STAGGER)
        rst_n_d[k] = 1'b1;
    end
    if (restart_i) rst_n_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      state_q     <= S_ASSERT;
      rst_n_q     <= '0;
      str_cnt     <= '0;
      rel_cnt     <= '0;
      stall_cnt   <= '0;
      last_pc     <= '0;
      pc_vld      <= 1'b0;
      cycle_cnt_o <= '0;
      final_pc_o  <= '0;
      done_o      <= 1'b0;
      halted_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      // The synchroniser stays released across restart, so a restart
      // starts the stretch immediately.
      sync_q  <= {sync_q[0], 1'b1};
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      if (restart_i) begin
        str_cnt     <= '0;
        rel_cnt     <= '0;
        stall_cnt   <= '0;
        last_pc     <= '0;
        pc_vld      <= 1'b0;
        cycle_cnt_o <= '0;
        final_pc_o  <= '0;
        done_o      <= 1'b0;
        halted_o    <= 1'b0;
        timeout_o   <= 1'b0;
      end else begin
        case (state_q)
          S_ASSERT: begin
            if (!sync_q[1] || str_done) str_cnt <= '0;
            else                        str_cnt <= str_cnt + ST_W'(1);
          end
          S_RELEASE: rel_cnt <= rel_cnt + REL_W'(1);
          S_RUN: begin
            last_pc   <= pc_i;
            pc_vld    <= 1'b1;
            stall_cnt <= stall_eq ? stall_cnt + SC_W'(1) : '0;
            if (halt_hit) begin
              halted_o   <= 1'b1;
              done_o     <= 1'b1;
              final_pc_o <= pc_i;
            end else if (tmo_hit) begin
              timeout_o  <= 1'b1;
              done_o     <= 1'b1;
              final_pc_o <= pc_i;
            end else begin
              cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rst_n_o   = rst_n_q;
  assign running_o = (state_q == S_RUN);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. The first instance uses the default
// parameters. The second uses four channels with no stagger. Termination
// results are queued when a run's PC pattern is chosen. They are checked when
// the DUT reports done.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, restart;
  logic [63:0] pc;
  logic [1:0]  rst_n;
  logic        running, done, halted, timeout;
  logic [15:0] cycle_cnt;
  logic [63:0] final_pc;

  logic        rst4, restart4;
  logic [63:0] pc4;
  logic [3:0]  rst_n4;
  logic        running4, done4, halted4, timeout4;
  logic [15:0] cycle_cnt4;
  logic [63:0] final_pc4;

  cpu_run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .restart_i(restart), .pc_i(pc),
    .rst_n_o(rst_n), .running_o(running), .done_o(done), .halted_o(halted),
    .timeout_o(timeout), .cycle_cnt_o(cycle_cnt), .final_pc_o(final_pc)
  );

  cpu_run_ctrl #(.N_RST(4), .STAGGER(0)) dut4 (
    .clk_i(clk), .rst_i(rst4), .restart_i(restart4), .pc_i(pc4),
    .rst_n_o(rst_n4), .running_o(running4), .done_o(done4), .halted_o(halted4),
    .timeout_o(timeout4), .cycle_cnt_o(cycle_cnt4), .final_pc_o(final_pc4)
  );

  typedef struct {
    logic        halted;
    logic        timeout;
    logic [15:0] cnt;
    logic [63:0] fpc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts the edges until running_o is seen, giving up after 60 edges.
  task automatic wait_run(input string tag, input int exp_edges);
    int n = 0;
    while (running !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_edges));
  endtask

  // RUN cycle i sees base+4*i until cycle 'stick', then holds that value.
  task automatic run_pc(input logic [63:0] base, input int stick, input int n);
    for (int i = 0; i < n; i++) begin
      pc = (i < stick) ? base + 64'(4 * i) : base + 64'(4 * stick);
      if (i == n - 1) chk("done_before_last", 64'(done), 64'(0));
      step();
    end
  endtask

  task automatic check_term(input string tag);
    exp_t e;
    chk({tag, "_sb_size"}, 64'(sb.size()), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_done"},    64'(done),      64'(1));
      chk({tag, "_running"}, 64'(running),   64'(0));
      chk({tag, "_halted"},  64'(halted),    64'(e.halted));
      chk({tag, "_timeout"}, 64'(timeout),   64'(e.timeout));
      chk({tag, "_cnt"},     64'(cycle_cnt), 64'(e.cnt));
      chk({tag, "_fpc"},     final_pc,       e.fpc);
      chk({tag, "_rst_n"},   64'(rst_n),     64'(2'b11));
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; pc = '0;
    rst4 = 1'b1; restart4 = 1'b0; pc4 = '0;
    repeat (3) step();

    chk("rst_rst_n",   64'(rst_n),     64'(0));
    chk("rst_running", 64'(running),   64'(0));
    chk("rst_done",    64'(done),      64'(0));
    chk("rst_halted",  64'(halted),    64'(0));
    chk("rst_timeout", 64'(timeout),   64'(0));
    chk("rst_cnt",     64'(cycle_cnt), 64'(0));
    chk("rst_fpc",     final_pc,       64'(0));

    // T1: deassert mid-cycle. There are 2 synchroniser edges and 4 stretch
    // edges. Bit 1 releases 2 edges after bit 0.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t1_rst_n_e%0d", k), 64'(rst_n),
          64'((k < 6) ? 2'b00 : (k < 8) ? 2'b01 : 2'b11));
    end
    chk("t1_running", 64'(running), 64'(1));

    // T2: the PC sticks at 0x80 from cycle 32. Seven equal compares put the
    // halt in cycle 39.
    sb.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 16'd39, fpc: 64'h80});
    run_pc(64'h0, 32, 40);
    check_term("t2");

    // Restart from HALTED clears everything on the next edge.
    pulse_restart();
    chk("rs_rst_n",   64'(rst_n),     64'(0));
    chk("rs_halted",  64'(halted),    64'(0));
    chk("rs_done",    64'(done),      64'(0));
    chk("rs_cnt",     64'(cycle_cnt), 64'(0));
    chk("rs_fpc",     final_pc,       64'(0));

    // T5: restart while RELEASE has only bit 0 out.
    repeat (4) step();
    chk("t5_mid_rst_n", 64'(rst_n), 64'(2'b01));
    pulse_restart();
    chk("t5_rst_n",    64'(rst_n),   64'(0));
    chk("t5_running",  64'(running), 64'(0));
    chk("t5_done",     64'(done),    64'(0));
    wait_run("t5_replay_edges", 6);
    chk("t5_replay_rst_n", 64'(rst_n), 64'(2'b11));

    // T3: the PC never repeats, so the run times out with the count at 119.
    sb.push_back('{halted: 1'b0, timeout: 1'b1, cnt: 16'd119,
                   fpc: 64'h1000 + 64'(4 * 119)});
    run_pc(64'h1000, 100000, 120);
    check_term("t3");

    // T4: the stall completes in cycle 119, the same cycle as the timeout.
    // The halt wins.
    pulse_restart();
    wait_run("t4_replay_edges", 6);
    sb.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 16'd119,
                   fpc: 64'h2000 + 64'(4 * 112)});
    run_pc(64'h2000, 112, 120);
    check_term("t4");

    // T6: with four channels and no stagger, all four release on edge 6.
    // A reset during RUN then clears them at once.
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t6_rst_n_e%0d", k), 64'(rst_n4),
          64'((k < 6) ? 4'h0 : 4'hF));
    end
    chk("t6_running", 64'(running4), 64'(1));
    for (int i = 0; i < 5; i++) begin
      pc4 = 64'(16 * i);
      step();
    end
    chk("t6_cnt_run", 64'(cycle_cnt4), 64'(5));
    #2;
    rst4 = 1'b1;
    #1;
    chk("t6_async_rst_n",   64'(rst_n4),     64'(0));
    chk("t6_async_cnt",     64'(cycle_cnt4), 64'(0));
    chk("t6_async_running", 64'(running4),   64'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
